// File: rtl/alu_pkg.sv
// Shared ALU control encodings. The ALU control decoder imports the same constants.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic is_legal_alu_ctrl(input logic [2:0] ctrl);
        return (ctrl == ALU_AND) || (ctrl == ALU_OR) || (ctrl == ALU_ADD) ||
               (ctrl == ALU_SUB) || (ctrl == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: result, signed overflow for ADD/SUB, and illegal-code flag.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             illegal
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;

    assign sum     = a + b;
    assign diff    = a - b;
    assign add_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
    assign sub_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        illegal  = 1'b0;
        case (ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: begin
                result   = sum;
                overflow = add_ovf;
            end
            ALU_SUB: begin
                result   = diff;
                overflow = sub_ovf;
            end
            // Signed less-than: the sign of a-b is wrong exactly when the subtraction overflowed.
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, diff[MSB] ^ sub_ovf};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ex_stage.sv
// Execute stage: ALU core feeding the EX/MEM register, with stall/flush priority
// and a saturating illegal-op counter.
module alu_ex_stage
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [2:0]           alu_ctrl,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic [4:0]           rd_in,
    input  logic                 reg_write_in,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     alu_result,
    output logic                 zero,
    output logic                 overflow,
    output logic                 illegal_op,
    output logic [4:0]           rd_out,
    output logic                 reg_write_out,
    output logic [CNT_WIDTH-1:0] illegal_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [WIDTH-1:0] core_result;
    logic             core_overflow;
    logic             core_illegal;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .ctrl     (alu_ctrl),
        .a        (op_a),
        .b        (op_b),
        .result   (core_result),
        .overflow (core_overflow),
        .illegal  (core_illegal)
    );

    // Priority per edge: reset, then flush, then stall, then load (bubble when in_valid is low).
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            alu_result    <= '0;
            zero          <= 1'b0;
            overflow      <= 1'b0;
            illegal_op    <= 1'b0;
            rd_out        <= '0;
            reg_write_out <= 1'b0;
            illegal_count <= '0;
        end else if (flush || (!stall && !in_valid)) begin
            out_valid     <= 1'b0;
            alu_result    <= '0;
            zero          <= 1'b0;
            overflow      <= 1'b0;
            illegal_op    <= 1'b0;
            rd_out        <= '0;
            reg_write_out <= 1'b0;
        end else if (!stall) begin
            out_valid     <= 1'b1;
            alu_result    <= core_result;
            zero          <= (core_result == '0);
            overflow      <= core_overflow;
            illegal_op    <= core_illegal;
            rd_out        <= rd_in;
            reg_write_out <= reg_write_in & ~core_illegal;
            if (core_illegal && (illegal_count != CNT_MAX)) begin
                illegal_count <= illegal_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed self-checking bench for alu_ex_stage with hand-computed expected values.
module tb_alu_ex_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [2:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        out_valid;
    logic [31:0] alu_result;
    logic        zero;
    logic        overflow;
    logic        illegal_op;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic [7:0]  illegal_count;

    int total = 0;
    int bad   = 0;

    alu_ex_stage #(.WIDTH(32), .CNT_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .in_valid      (in_valid),
        .alu_ctrl      (alu_ctrl),
        .op_a          (op_a),
        .op_b          (op_b),
        .rd_in         (rd_in),
        .reg_write_in  (reg_write_in),
        .out_valid     (out_valid),
        .alu_result    (alu_result),
        .zero          (zero),
        .overflow      (overflow),
        .illegal_op    (illegal_op),
        .rd_out        (rd_out),
        .reg_write_out (reg_write_out),
        .illegal_count (illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge, so outputs are sampled away from it too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic rw);
        in_valid     = v;
        alu_ctrl     = c;
        op_a         = a;
        op_b         = b;
        rd_in        = rd;
        reg_write_in = rw;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 3'b010, 32'd1, 32'd2, 5'd3, 1'b1);
        tick();
        tick();
        reset = 1'b0;
        total++;
        if ({out_valid, alu_result, zero, overflow, illegal_op, rd_out, reg_write_out, illegal_count} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_state: valid=%b res=%h z=%b ovf=%b ill=%b rd=%0d rw=%b cnt=%0d, required all 0",
                     out_valid, alu_result, zero, overflow, illegal_op, rd_out, reg_write_out, illegal_count);
        end
    endtask

    task automatic test_add_overflow();
        drive(1'b1, 3'b010, 32'h7FFF_FFFF, 32'h1, 5'd7, 1'b1);
        tick();
        total++;
        if ({out_valid, alu_result, overflow, zero, reg_write_out, rd_out} !== {1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 5'd7}) begin
            bad++;
            $display("[TB] FAIL add_overflow: valid=%b res=%h ovf=%b z=%b rw=%b rd=%0d, required 1 80000000 1 0 1 7",
                     out_valid, alu_result, overflow, zero, reg_write_out, rd_out);
        end
    endtask

    task automatic test_sub_slt();
        drive(1'b1, 3'b110, 32'd5, 32'd5, 5'd2, 1'b1);
        tick();
        total++;
        if ({alu_result, zero, overflow} !== {32'h0, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL sub_zero: res=%h z=%b ovf=%b, required 0 1 0", alu_result, zero, overflow);
        end
        drive(1'b1, 3'b110, 32'h8000_0000, 32'h1, 5'd2, 1'b1);
        tick();
        total++;
        if ({alu_result, overflow} !== {32'h7FFF_FFFF, 1'b1}) begin
            bad++;
            $display("[TB] FAIL sub_overflow: res=%h ovf=%b, required 7fffffff 1", alu_result, overflow);
        end
        drive(1'b1, 3'b111, 32'h8000_0000, 32'h1, 5'd4, 1'b1);
        tick();
        total++;
        if ({alu_result, overflow, zero} !== {32'h1, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL slt_neg_lt_pos: res=%h ovf=%b z=%b, required 1 0 0", alu_result, overflow, zero);
        end
        drive(1'b1, 3'b111, 32'h1, 32'h8000_0000, 5'd4, 1'b1);
        tick();
        total++;
        if ({alu_result, zero} !== {32'h0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL slt_pos_lt_neg: res=%h z=%b, required 0 1", alu_result, zero);
        end
    endtask

    task automatic test_logic();
        drive(1'b1, 3'b000, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd9, 1'b0);
        tick();
        total++;
        if ({alu_result, reg_write_out, overflow} !== {32'h00F0_1200, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL and_op: res=%h rw=%b ovf=%b, required 00f01200 0 0", alu_result, reg_write_out, overflow);
        end
        drive(1'b1, 3'b001, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd9, 1'b1);
        tick();
        total++;
        if ({alu_result, reg_write_out} !== {32'hFFF0_FF34, 1'b1}) begin
            bad++;
            $display("[TB] FAIL or_op: res=%h rw=%b, required fff0ff34 1", alu_result, reg_write_out);
        end
    endtask

    task automatic test_illegal();
        drive(1'b1, 3'b101, 32'hFFFF_FFFF, 32'h1, 5'd11, 1'b1);
        tick();
        total++;
        if ({illegal_op, alu_result, reg_write_out, out_valid, overflow, illegal_count} !==
            {1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 8'd1}) begin
            bad++;
            $display("[TB] FAIL illegal_first: ill=%b res=%h rw=%b valid=%b ovf=%b cnt=%0d, required 1 0 0 1 0 1",
                     illegal_op, alu_result, reg_write_out, out_valid, overflow, illegal_count);
        end
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, (i % 2 == 0) ? 3'b011 : 3'b100, i, 32'h5, 5'd11, 1'b1);
            tick();
        end
        total++;
        if (illegal_count !== 8'd255) begin
            bad++;
            $display("[TB] FAIL illegal_saturate: cnt=%0d, required 255", illegal_count);
        end
        // No wrap to zero on a further illegal op.
        drive(1'b1, 3'b101, 32'h0, 32'h0, 5'd11, 1'b1);
        tick();
        total++;
        if (illegal_count !== 8'd255) begin
            bad++;
            $display("[TB] FAIL illegal_no_wrap: cnt=%0d, required 255", illegal_count);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 3'b010, 32'd2, 32'd3, 5'd6, 1'b1);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, (i == 1) ? 3'b101 : 3'b110, 32'd9 + i, 32'd1, 5'd20 + i, 1'b0);
            tick();
            total++;
            if ({alu_result, out_valid, rd_out, reg_write_out, illegal_op, illegal_count} !==
                {32'd5, 1'b1, 5'd6, 1'b1, 1'b0, 8'd255}) begin
                bad++;
                $display("[TB] FAIL stall_hold%0d: res=%0d valid=%b rd=%0d rw=%b ill=%b cnt=%0d, required 5 1 6 1 0 255",
                         i, alu_result, out_valid, rd_out, reg_write_out, illegal_op, illegal_count);
            end
        end
        stall = 1'b0;
        drive(1'b1, 3'b110, 32'd9, 32'd1, 5'd21, 1'b1);
        tick();
        total++;
        if ({alu_result, rd_out, out_valid} !== {32'd8, 5'd21, 1'b1}) begin
            bad++;
            $display("[TB] FAIL stall_release: res=%0d rd=%0d valid=%b, required 8 21 1", alu_result, rd_out, out_valid);
        end
    endtask

    task automatic test_flush_bubble();
        stall = 1'b1; flush = 1'b1;
        drive(1'b1, 3'b010, 32'd4, 32'd4, 5'd3, 1'b1);
        tick();
        stall = 1'b0; flush = 1'b0;
        total++;
        if ({out_valid, reg_write_out, alu_result, rd_out, zero, overflow, illegal_op} !== '0) begin
            bad++;
            $display("[TB] FAIL flush_over_stall: valid=%b rw=%b res=%h rd=%0d z=%b ovf=%b ill=%b, required all 0",
                     out_valid, reg_write_out, alu_result, rd_out, zero, overflow, illegal_op);
        end
        drive(1'b1, 3'b001, 32'd1, 32'd0, 5'd1, 1'b1);
        tick();
        drive(1'b0, 3'b101, 32'd0, 32'd0, 5'd12, 1'b1);
        tick();
        total++;
        if ({out_valid, reg_write_out, alu_result, rd_out, zero, illegal_op, illegal_count} !==
            {1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 8'd255}) begin
            bad++;
            $display("[TB] FAIL invalid_bubble: valid=%b rw=%b res=%h rd=%0d z=%b ill=%b cnt=%0d, required 0 0 0 0 0 0 255",
                     out_valid, reg_write_out, alu_result, rd_out, zero, illegal_op, illegal_count);
        end
    endtask

    task automatic test_reset_in_stall();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 3'b011, 32'd1, 32'd1, 5'd5, 1'b1);
            tick();
        end
        // A flush with an illegal code must not count.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if (illegal_count !== 8'd7) begin
            bad++;
            $display("[TB] FAIL count_seven: cnt=%0d, required 7", illegal_count);
        end
        drive(1'b1, 3'b010, 32'd1, 32'd1, 5'd5, 1'b1);
        tick();
        stall = 1'b1;
        drive(1'b1, 3'b011, 32'd1, 32'd1, 5'd5, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        stall = 1'b0;
        total++;
        if ({out_valid, alu_result, zero, overflow, illegal_op, rd_out, reg_write_out, illegal_count} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_in_stall: valid=%b res=%h rw=%b rd=%0d cnt=%0d, required all 0",
                     out_valid, alu_result, reg_write_out, rd_out, illegal_count);
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_slt();
        test_logic();
        test_illegal();
        test_stall();
        test_flush_bubble();
        test_reset_in_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
